// File: rtl/tc_pkg.sv
// Purpose : shared constants for the parade traffic-controller input conditioning.
// Latency : n/a (constants only).
// Backpressure: n/a.
package tc_pkg;

  localparam int unsigned TC_CLK_HZ      = 100000000;
  localparam int unsigned TC_STEP_CYCLES = 500000000;  // 5 s controller step
  localparam int unsigned TC_DB_CYCLES   = 2000000;    // 20 ms debounce window
  localparam int unsigned TC_FAST_TICK   = 16;
  localparam int unsigned TC_FAST_DB     = 4;
  localparam int unsigned TC_TICK_W      = 32;
  localparam int unsigned TC_DB_W        = 24;

endpackage : tc_pkg

// File: rtl/tc_debounce.sv
// Purpose : 2-flop synchroniser plus counter debounce for one raw asynchronous input.
// Latency : 2 + DB_CYCLES cycles from pin change to stable level change.
// Backpressure: none; free-running, samples every cycle.
//
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   din    - raw asynchronous input
//   stable - debounced level (flop output)
module tc_debounce
  import tc_pkg::*;
#(
  parameter int unsigned DB_CYCLES = TC_DB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic stable
);

  localparam logic [TC_DB_W-1:0] DB_LAST = TC_DB_W'(DB_CYCLES - 1);

  logic               sync1_q, sync2_q;
  logic               stable_q, stable_d;
  logic [TC_DB_W-1:0] cnt_q, cnt_d;

  // The counter only runs while the synced value disagrees with the accepted
  // level; any agreeing cycle restarts the window, so short glitches vanish.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == DB_LAST) begin
        stable_d = ~stable_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= din;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule : tc_debounce

// File: rtl/tc_input_cond.sv
// Purpose : debounce P/R/T_A/T_B, latch button presses and deliver them on the step enable.
// Latency : sensors 3 + DB cycles pin-to-output; requests appear the cycle after the next TICK.
// Backpressure: none; requests are held pending until the next TICK, repeats collapse.
//
// Build option: TC_FAST_SIM_EN forces a 16-cycle step and 4-cycle debounce.
// Ports:
//   CLK_100M - 100 MHz system clock        RESET - async active-low reset
//   P, R     - raw parade/release buttons  T_A, T_B - raw traffic sensors
//   TICK     - one-cycle step enable       P_Q, R_Q - requests, held one full step
//   T_A_Q, T_B_Q - debounced sensor levels
module tc_input_cond
  import tc_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = TC_STEP_CYCLES,
  parameter int unsigned DB_CYCLES   = TC_DB_CYCLES
) (
  input  logic CLK_100M,
  input  logic RESET,
  input  logic P,
  input  logic R,
  input  logic T_A,
  input  logic T_B,
  output logic TICK,
  output logic P_Q,
  output logic R_Q,
  output logic T_A_Q,
  output logic T_B_Q
);

`ifdef TC_FAST_SIM_EN
  localparam int unsigned TICK_EFF = TC_FAST_TICK;
  localparam int unsigned DB_EFF   = TC_FAST_DB;
`else
  localparam int unsigned TICK_EFF = TICK_CYCLES;
  localparam int unsigned DB_EFF   = DB_CYCLES;
`endif

  localparam logic [TC_TICK_W-1:0] TICK_LAST = TC_TICK_W'(TICK_EFF - 1);

  logic p_stable, r_stable, ta_stable, tb_stable;

  tc_debounce #(.DB_CYCLES(DB_EFF)) u_db_p  (.clk(CLK_100M), .rst_n(RESET), .din(P),   .stable(p_stable));
  tc_debounce #(.DB_CYCLES(DB_EFF)) u_db_r  (.clk(CLK_100M), .rst_n(RESET), .din(R),   .stable(r_stable));
  tc_debounce #(.DB_CYCLES(DB_EFF)) u_db_ta (.clk(CLK_100M), .rst_n(RESET), .din(T_A), .stable(ta_stable));
  tc_debounce #(.DB_CYCLES(DB_EFF)) u_db_tb (.clk(CLK_100M), .rst_n(RESET), .din(T_B), .stable(tb_stable));

  logic [TC_TICK_W-1:0] cnt_q, cnt_d;
  logic                 tick_q, tick_d;
  logic                 p_prev_q, r_prev_q;
  logic                 p_pend_q, p_pend_d, r_pend_q, r_pend_d;
  logic                 p_q_q, p_q_d, r_q_q, r_q_d;
  logic                 ta_q_q, tb_q_q;
  logic                 p_rise, r_rise;

  assign p_rise = p_stable & ~p_prev_q;
  assign r_rise = r_stable & ~r_prev_q;

  always_comb begin
    cnt_d = (cnt_q == TICK_LAST) ? '0 : cnt_q + 1'b1;
    // Registered so TICK is high exactly while cnt_q holds the last count.
    tick_d = (cnt_d == TICK_LAST);

    p_pend_d = p_pend_q | p_rise;
    r_pend_d = r_pend_q | r_rise;
    p_q_d    = p_q_q;
    r_q_d    = r_q_q;
    if (tick_q) begin
      // Release has priority; a losing parade request is dropped, not deferred.
      r_q_d    = r_pend_q;
      p_q_d    = p_pend_q & ~r_pend_q;
      // An edge landing on the tick itself is kept for the following step.
      p_pend_d = p_rise;
      r_pend_d = r_rise;
    end
  end

  always_ff @(posedge CLK_100M or negedge RESET) begin
    if (!RESET) begin
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      p_prev_q <= 1'b0;
      r_prev_q <= 1'b0;
      p_pend_q <= 1'b0;
      r_pend_q <= 1'b0;
      p_q_q    <= 1'b0;
      r_q_q    <= 1'b0;
      ta_q_q   <= 1'b0;
      tb_q_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      p_prev_q <= p_stable;
      r_prev_q <= r_stable;
      p_pend_q <= p_pend_d;
      r_pend_q <= r_pend_d;
      p_q_q    <= p_q_d;
      r_q_q    <= r_q_d;
      ta_q_q   <= ta_stable;
      tb_q_q   <= tb_stable;
    end
  end

  assign TICK  = tick_q;
  assign P_Q   = p_q_q;
  assign R_Q   = r_q_q;
  assign T_A_Q = ta_q_q;
  assign T_B_Q = tb_q_q;

endmodule : tc_input_cond

// File: tb/tb_tc_input_cond.sv
// Directed bench for tc_input_cond with a 16-cycle step and 4-cycle debounce.
// Cycle 0 is the interval right after RESET is released; inputs are driven and
// outputs sampled 1 time unit after each rising edge.
module tb_tc_input_cond;

  logic CLK_100M = 1'b0;
  logic RESET    = 1'b0;
  logic P = 1'b0, R = 1'b0, T_A = 1'b0, T_B = 1'b0;
  logic TICK, P_Q, R_Q, T_A_Q, T_B_Q;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  tc_input_cond #(.TICK_CYCLES(16), .DB_CYCLES(4)) dut (
    .CLK_100M(CLK_100M), .RESET(RESET),
    .P(P), .R(R), .T_A(T_A), .T_B(T_B),
    .TICK(TICK), .P_Q(P_Q), .R_Q(R_Q), .T_A_Q(T_A_Q), .T_B_Q(T_B_Q)
  );

  always #5 CLK_100M = ~CLK_100M;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK_100M);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    P = 1'b0; R = 1'b0; T_A = 1'b0; T_B = 1'b0;
    repeat (3) @(posedge CLK_100M);
    #1;
    RESET = 1'b1;
    cyc   = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tick"}, 32'(TICK),  0);
    chk({tag, "_pq"},   32'(P_Q),   0);
    chk({tag, "_rq"},   32'(R_Q),   0);
    chk({tag, "_taq"},  32'(T_A_Q), 0);
    chk({tag, "_tbq"},  32'(T_B_Q), 0);
  endtask

  initial begin
    // 1. Reset state and tick cadence.
    do_reset();
    chk_all_zero("rst");
    for (int c = 0; c <= 48; c++) begin
      chk("tick_cadence", 32'(TICK), 32'(c == 15 || c == 31 || c == 47));
      step();
    end

    // 1b. Asynchronous reset at cycle 20 with P_Q and T_A_Q high.
    do_reset();
    T_A = 1'b1;
    for (int c = 0; c <= 19; c++) begin
      if (c == 3)  P = 1'b1;
      if (c == 13) P = 1'b0;
      step();
    end
    chk("pre_rst_pq",  32'(P_Q),   1);
    chk("pre_rst_taq", 32'(T_A_Q), 1);
    RESET = 1'b0;
    T_A   = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge CLK_100M);
    #1;
    RESET = 1'b1;
    cyc   = 0;
    for (int c = 0; c <= 16; c++) begin
      chk("tick_after_rerelease", 32'(TICK), 32'(c == 15));
      chk("pq_after_rerelease",   32'(P_Q),  0);
      step();
    end

    // 2. Sensor debounce: glitch, held edge, fast toggling.
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      T_A = (c <= 2);
      chk("ta_glitch", 32'(T_A_Q), 0);
      step();
    end
    T_A = 1'b1;  // cycle 13
    for (int c = 13; c <= 23; c++) begin
      chk("ta_held", 32'(T_A_Q), 32'(c >= 20));
      step();
    end
    for (int c = 24; c <= 40; c++) begin
      T_A = ((c - 24) % 4) >= 2;
      chk("ta_toggle", 32'(T_A_Q), 1);
      step();
    end
    chk("tb_idle", 32'(T_B_Q), 0);

    // 3. Single P press delivered for one full step.
    do_reset();
    for (int c = 0; c <= 40; c++) begin
      if (c == 3)  P = 1'b1;
      if (c == 13) P = 1'b0;
      chk("p_single_pq", 32'(P_Q), 32'(c >= 16 && c <= 31));
      chk("p_single_rq", 32'(R_Q), 0);
      step();
    end

    // 4. P and R in the same step: R wins, both pending flags clear.
    do_reset();
    for (int c = 0; c <= 40; c++) begin
      if (c == 2)  P = 1'b1;
      if (c == 5)  R = 1'b1;
      if (c == 12) P = 1'b0;
      if (c == 15) R = 1'b0;
      chk("prio_rq", 32'(R_Q), 32'(c >= 16 && c <= 31));
      chk("prio_pq", 32'(P_Q), 0);
      if (c == 16) begin
        chk("prio_ppend_clr", 32'(dut.p_pend_q), 0);
        chk("prio_rpend_clr", 32'(dut.r_pend_q), 0);
      end
      step();
    end

    // 5. Debounced P edge landing exactly on the TICK at cycle 31.
    do_reset();
    for (int c = 0; c <= 64; c++) begin
      if (c == 25) P = 1'b1;
      if (c == 35) P = 1'b0;
      if (c == 31) chk("edge_on_tick_tick", 32'(TICK), 1);
      chk("edge_on_tick_pq", 32'(P_Q), 32'(c >= 48 && c <= 63));
      step();
    end

    // 6. Several presses in one step collapse into a single request.
    do_reset();
    for (int c = 0; c <= 48; c++) begin
      P = (c <= 3) || (c >= 8 && c <= 11) || (c == 13) || (c == 14);
      chk("multi_pq", 32'(P_Q), 32'(c >= 16 && c <= 31));
      chk("multi_rq", 32'(R_Q), 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_tc_input_cond
